// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO stream reader and its skid buffer.
// Holds the default data width, skid depth and the occupancy update function.
package fifo_pkg;

    localparam int         DWIDTH_DEF = 4;
    localparam int         SKID_DEPTH = 2;
    localparam logic [1:0] OCC_EMPTY  = 2'd0;
    localparam logic [1:0] OCC_FULL   = 2'd2;

    typedef logic [7:0] xfer_cnt_t;

    // Occupancy after one edge; a simultaneous push and pop cancel out.
    function automatic logic [1:0] occ_next(input logic [1:0] occ,
                                            input logic       push,
                                            input logic       pop);
        occ_next = occ + {1'b0, push} - {1'b0, pop};
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between the upstream show-ahead FIFO, the reader and the stream consumer.
// The master modport is the reader itself; slave is the surrounding environment.
interface fifo_stream_reader_if
    import fifo_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
);

    logic              fifo_empty;
    logic [DWIDTH-1:0] fifo_dout;
    logic              fifo_ren;
    logic              m_valid;
    logic              m_ready;
    logic [DWIDTH-1:0] m_data;
    logic              flush;
    xfer_cnt_t         xfer_count;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  m_ready,
        input  flush,
        output fifo_ren,
        output m_valid,
        output m_data,
        output xfer_count
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output m_ready,
        output flush,
        input  fifo_ren,
        input  m_valid,
        input  m_data,
        input  xfer_count
    );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer: storage plus head/tail pointers and occupancy.
// Storage words are deliberately not reset; only the bookkeeping is.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DWIDTH-1:0] wdata_i,
    output logic [DWIDTH-1:0] rdata_o,
    output logic [1:0]        occ_o
);

    logic [DWIDTH-1:0] buf_q [SKID_DEPTH];
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic [1:0]        occ_q, occ_d;

    // Next-state for pointers and occupancy; flush returns everything to empty.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (flush_i) begin
            head_d = 1'b0;
            tail_d = 1'b0;
            occ_d  = OCC_EMPTY;
        end else begin
            if (push_i) begin
                tail_d = ~tail_q;
            end else begin
                tail_d = tail_q;
            end
            if (pop_i) begin
                head_d = ~head_q;
            end else begin
                head_d = head_q;
            end
            occ_d = occ_next(occ_q, push_i, pop_i);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= 1'b0;
            tail_q <= 1'b0;
            occ_q  <= OCC_EMPTY;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // Word storage, written at the tail slot on every push.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            buf_q[tail_q] <= wdata_i;
        end
    end

    assign rdata_o = buf_q[head_q];
    assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a show-ahead FIFO into a valid/ready stream through a 2-entry skid buffer.
// Pop request never looks at m_ready, so upstream timing stays decoupled from the consumer.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_stream_reader_if.master bus
);

    logic [1:0]        occ_s;
    logic [DWIDTH-1:0] rdata_s;
    logic              ren_s;
    logic              valid_s;
    logic              xfer_s;
    xfer_cnt_t         xfer_count_q, xfer_count_d;

    // Pop, valid and transfer qualifiers; flush and reset both suppress them.
    always_comb begin
        ren_s   = ~bus.fifo_empty & ~bus.flush & (occ_s != OCC_FULL) & ~rst;
        valid_s = (occ_s != OCC_EMPTY) & ~bus.flush;
        xfer_s  = valid_s & bus.m_ready;
    end

    // Transfer counter next-state, wrapping naturally at 256.
    always_comb begin
        xfer_count_d = xfer_count_q;
        if (xfer_s) begin
            xfer_count_d = xfer_count_q + 8'd1;
        end else begin
            xfer_count_d = xfer_count_q;
        end
    end

    // Transfer counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count_q <= 8'd0;
        end else begin
            xfer_count_q <= xfer_count_d;
        end
    end

    fifo_rd_skid #(
        .DWIDTH (DWIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.flush),
        .push_i  (ren_s),
        .pop_i   (xfer_s),
        .wdata_i (bus.fifo_dout),
        .rdata_o (rdata_s),
        .occ_o   (occ_s)
    );

    assign bus.fifo_ren   = ren_s;
    assign bus.m_valid    = valid_s;
    assign bus.m_data     = rdata_s;
    assign bus.xfer_count = xfer_count_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a queue-backed FIFO model feeds the DUT,
// expected words go into a scoreboard queue, and a monitor compares every transfer.
module tb_fifo_stream_reader;

    logic clk;
    logic rst;

    fifo_stream_reader_if #(.DWIDTH(4)) bus ();

    fifo_stream_reader #(.DWIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] src_q [$];
    logic [3:0] exp_q [$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ren_n = 0;
    int xf_n = 0;
    int first_ren = -1;
    int first_xf = -1;
    int last_xf = -1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic drive_fifo();
        bus.fifo_empty = (src_q.size() == 0);
        bus.fifo_dout  = (src_q.size() != 0) ? src_q[0] : 4'h0;
    endtask

    // One clock: sample handshakes at negedge, pop the model FIFO after the edge.
    task automatic step();
        logic r;
        logic x;
        logic [3:0] tmp;
        @(negedge clk);
        r = bus.fifo_ren;
        x = bus.m_valid & bus.m_ready;
        if (r) begin
            ren_n++;
            if (first_ren < 0) first_ren = cyc;
        end
        if (x) begin
            xf_n++;
            if (first_xf < 0) first_xf = cyc;
            last_xf = cyc;
        end
        @(posedge clk);
        #1;
        if (r) tmp = src_q.pop_front();
        cyc++;
        drive_fifo();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.m_ready = 1'b0;
        bus.flush = 1'b0;
        src_q.delete();
        drive_fifo();
        step();
        step();
        rst = 1'b0;
        ren_n = 0;
        xf_n = 0;
        first_ren = -1;
        first_xf = -1;
        last_xf = -1;
    endtask

    task automatic drain(input string nm, input int budget);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) step();
        check(nm, exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.m_ready = 1'b0;
        bus.flush = 1'b0;
        src_q.push_back(4'h9);
        drive_fifo();

        // Scoreboard monitor: every transfer must match the next expected word.
        fork
            forever begin
                @(negedge clk);
                if (!rst && bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_xfer", {28'd0, bus.m_data}, 32'hFFFF_FFFF);
                    end else begin
                        check("sb_data", {28'd0, bus.m_data}, {28'd0, exp_q.pop_front()});
                    end
                end
            end
        join_none

        // Reset with a non-empty FIFO: nothing is popped or presented.
        step();
        check("rst_ren", bus.fifo_ren, 0);
        check("rst_valid", bus.m_valid, 0);
        check("rst_xfer_count", bus.xfer_count, 0);
        check("rst_no_pop", src_q.size(), 1);

        // Single word with one-cycle latency.
        do_reset();
        bus.m_ready = 1'b1;
        src_q.push_back(4'hA);
        exp_q.push_back(4'hA);
        drive_fifo();
        #1;
        check("single_ren_c0", bus.fifo_ren, 1);
        step();
        #1;
        check("single_valid_c1", bus.m_valid, 1);
        check("single_data_c1", bus.m_data, 4'hA);
        step();
        #1;
        check("single_xfer_count_c2", bus.xfer_count, 1);
        check("single_valid_c2", bus.m_valid, 0);

        // Backpressure: exactly two pops fill the skid, head word held stable.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            src_q.push_back(4'(i));
            exp_q.push_back(4'(i));
        end
        drive_fifo();
        for (int i = 0; i < 6; i++) begin
            step();
            #1;
            if (i > 0) check("bp_data_stable", bus.m_data, 0);
        end
        check("bp_ren_pulses", ren_n, 2);
        check("bp_valid", bus.m_valid, 1);
        check("bp_ren_held_low", bus.fifo_ren, 0);
        bus.m_ready = 1'b1;
        drain("bp_drain", 40);
        step();
        #1;
        check("bp_xfer_count", bus.xfer_count, 13);

        // Streaming: 13 back-to-back transfers starting one cycle after the first pop.
        do_reset();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            src_q.push_back(4'((3 * i + 1) % 16));
            exp_q.push_back(4'((3 * i + 1) % 16));
        end
        drive_fifo();
        for (int k = 0; k < 40 && xf_n < 13; k++) step();
        check("stream_xfers", xf_n, 13);
        check("stream_first_latency", first_xf - first_ren, 1);
        check("stream_no_bubbles", last_xf - first_xf, 12);
        drain("stream_drain", 4);

        // Flush at occ=2 discards both words, then 4'h5 flows normally.
        do_reset();
        src_q.push_back(4'h3);
        src_q.push_back(4'h4);
        drive_fifo();
        step();
        step();
        src_q.push_back(4'h5);
        exp_q.push_back(4'h5);
        drive_fifo();
        #1;
        check("full_hold_ren", bus.fifo_ren, 0);
        check("full_head_data", bus.m_data, 4'h3);
        bus.flush = 1'b1;
        bus.m_ready = 1'b1;
        #1;
        check("flush_valid", bus.m_valid, 0);
        check("flush_ren", bus.fifo_ren, 0);
        step();
        bus.flush = 1'b0;
        #1;
        check("post_flush_valid", bus.m_valid, 0);
        check("post_flush_ren", bus.fifo_ren, 1);
        check("flush_xfer_count", bus.xfer_count, 0);
        step();
        #1;
        check("after_flush_data", bus.m_data, 4'h5);
        step();
        #1;
        check("after_flush_xfer_count", bus.xfer_count, 1);
        drain("flush_drain", 4);

        // Mid-operation reset drops the buffered words and pops only after release.
        do_reset();
        src_q.push_back(4'h1);
        src_q.push_back(4'h2);
        drive_fifo();
        step();
        step();
        src_q.push_back(4'h7);
        drive_fifo();
        rst = 1'b1;
        #1;
        check("midrst_valid", bus.m_valid, 0);
        check("midrst_ren", bus.fifo_ren, 0);
        step();
        rst = 1'b0;
        bus.m_ready = 1'b1;
        exp_q.push_back(4'h7);
        #1;
        check("midrst_ren_after", bus.fifo_ren, 1);
        drain("midrst_drain", 6);

        // Counter wrap at 256 transfers.
        do_reset();
        bus.m_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            src_q.push_back(4'(i));
            exp_q.push_back(4'(i));
        end
        drive_fifo();
        for (int k = 0; k < 400 && xf_n < 256; k++) step();
        check("wrap_256_reached", xf_n, 256);
        check("wrap_256_count", bus.xfer_count, 0);
        for (int k = 0; k < 10 && xf_n < 257; k++) step();
        check("wrap_257_count", bus.xfer_count, 1);
        drain("wrap_drain", 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter: DWIDTH, default 4, data width of the FIFO read port and the output stream.
REQ-002 Port: clk  input  1  single clock; all logic is rising-edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: fifo_empty  input  1  FIFO empty flag from the upstream FIFO.
REQ-005 Port: fifo_dout  input  DWIDTH  FIFO show-ahead read data, valid in the same cycle as fifo_ren when fifo_empty=0.
REQ-006 Port: fifo_ren  output  1  FIFO pop request.
REQ-007 Port: m_valid  output  1  output stream data valid.
REQ-008 Port: m_ready  input  1  output stream consumer ready.
REQ-009 Port: m_data  output  DWIDTH  output stream data.
REQ-010 Port: flush  input  1  synchronous discard of buffered words.
REQ-011 Port: xfer_count  output  8  count of completed output transfers, modulo 256.

Function
REQ-012 Block SHALL hold a 2-entry skid buffer with a 1-bit head pointer, a 1-bit tail pointer and a 2-bit occupancy occ in the range 0..2.
REQ-013 fifo_ren SHALL equal ~fifo_empty & ~flush & (occ != 2) & ~rst; it SHALL NOT depend combinationally on m_ready.
REQ-014 When fifo_ren=1, fifo_dout SHALL be written to buffer[tail] at that clock edge, and tail SHALL toggle.
REQ-015 m_valid SHALL equal (occ != 0) & ~flush; m_data SHALL equal buffer[head].
REQ-016 A transfer SHALL occur when m_valid & m_ready; head SHALL toggle and xfer_count SHALL increment, wrapping from 255 to 0.
REQ-017 occ_next SHALL equal occ + fifo_ren - transfer. A simultaneous push and pop SHALL leave occ unchanged.
REQ-018 Latency: fifo_ren asserted at cycle N SHALL give m_valid=1 with that word at cycle N+1 when occ=0 at N.
REQ-019 Throughput: with m_ready held at 1 and fifo_empty held at 0, one transfer SHALL occur per cycle after the first word, with no bubbles.
REQ-020 Ordering: words SHALL leave in exactly the order in which they were popped; there SHALL be no loss or duplication except on flush.
REQ-021 m_data SHALL hold stable while m_valid=1 and m_ready=0.
REQ-022 Flush SHALL take precedence: in the flush cycle there SHALL be no push and no transfer, xfer_count SHALL be unchanged, and occ, head and tail SHALL be 0 at the next edge.
REQ-023 occ=2 with fifo_empty=0 SHALL hold fifo_ren=0, so the upstream FIFO retains its data.
REQ-024 fifo_empty=1 SHALL hold fifo_ren=0 regardless of occ; fifo_dout SHALL be ignored.

Reset
REQ-025 While rst=1: occ, head, tail and xfer_count SHALL be 0; m_valid SHALL be 0; fifo_ren SHALL be 0.
REQ-026 A mid-operation reset SHALL discard buffered words immediately, and no pop SHALL be issued until the first cycle after rst deasserts.
REQ-027 Buffer storage SHALL NOT be reset.

Structure
REQ-028 The shared package fifo_pkg SHALL hold the DWIDTH default and SKID_DEPTH=2.
REQ-029 Storage plus head/tail/occ SHALL be the sub-module fifo_rd_skid; the top level SHALL hold the ren logic, flush and xfer_count.

Verification
REQ-030 Reset: rst=1 with fifo_empty=0 -> fifo_ren=0, m_valid=0, xfer_count=0.
REQ-031 Single word: fifo_empty=0 for one cycle, fifo_dout=4'hA, m_ready=1 -> fifo_ren=1 at cycle 0; m_valid=1 with m_data=4'hA at cycle 1; xfer_count=1 at cycle 2.
REQ-032 Backpressure: 13-entry FIFO holding 0..12, m_ready=0 -> exactly 2 fifo_ren pulses and m_data=0 held stable; then m_ready=1 -> outputs 0..12 in order and xfer_count=13.
REQ-033 Streaming: m_ready=1 with 13 queued words -> 13 consecutive transfer cycles beginning one cycle after the first fifo_ren.
REQ-034 Flush at occ=2 -> m_valid=0 in the flush cycle and after it, xfer_count unchanged; the next FIFO word (4'h5) is output normally.
REQ-035 Wrap: 256 transfers -> xfer_count=0; 257 transfers -> xfer_count=1.
